// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD scan sequencer.
// Optional position skipping is enabled with BCD_SCAN_SKIP_MASK_EN.
package bcd_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'b1111;
  localparam logic [3:0] MAX_IDX    = 4'd10;
  localparam int         NUM_POS    = 11;

  // Position indices above the last decoder output are folded onto it.
  function automatic logic [3:0] clamp_last(input logic [3:0] v);
    return (v > MAX_IDX) ? MAX_IDX : v;
  endfunction

endpackage

// File: rtl/bcd_scan_next.sv
// Position sequencing helper: first, next and end-of-pass for the scan.
// With BCD_SCAN_SKIP_MASK_EN, masked positions are skipped.
module bcd_scan_next
  import bcd_scan_pkg::*;
(
  input  logic [3:0]         i_cur,
  input  logic [3:0]         i_last,
`ifdef BCD_SCAN_SKIP_MASK_EN
  input  logic [NUM_POS-1:0] i_mask,
`endif
  output logic [3:0]         o_first,
  output logic               o_none,
  output logic [3:0]         o_next,
  output logic               o_end
);

`ifdef BCD_SCAN_SKIP_MASK_EN
  // Walking downward lets the lowest qualifying index win.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_first = '0;
    o_none  = 1'b1;
    o_next  = '0;
    o_end   = 1'b1;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (!i_mask[i] && (i <= int'(i_last))) begin
        o_first = 4'(i);
        o_none  = 1'b0;
        if (i > int'(i_cur)) begin
          o_next = 4'(i);
          o_end  = 1'b0;
        end
      end
    end
  end
`else
  assign o_first = '0;
  assign o_none  = 1'b0;
  assign o_next  = i_cur + 4'd1;
  assign o_end   = (i_cur == i_last);
`endif

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Scan sequencer driving the BCD input of an 11-output one-hot decoder.
// Optional skip mask input is enabled with BCD_SCAN_SKIP_MASK_EN.
module bcd_scan_ctrl
  import bcd_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               START,
  input  logic               STOP,
  input  logic               CONT,
  input  logic [3:0]         LAST,
  input  logic [DWELL_W-1:0] DWELL,
`ifdef BCD_SCAN_SKIP_MASK_EN
  input  logic [NUM_POS-1:0] MASK,
`endif
  output logic [3:0]         B,
  output logic               BUSY,
  output logic               STEP,
  output logic               DONE
);

  state_e             r_state, w_state_nxt;
  logic [3:0]         r_b, w_b_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_step, w_step_nxt;
  logic               r_done, w_done_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_cont, w_cont_nxt;
  logic [3:0]         r_last, w_last_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [3:0]         w_sel_last;
  logic [3:0]         w_first, w_next;
  logic               w_none, w_end;

  // In IDLE the helper sees the live request so the first position is known at START.
  assign w_sel_last = (r_state == IDLE) ? clamp_last(LAST) : r_last;

`ifdef BCD_SCAN_SKIP_MASK_EN
  logic [NUM_POS-1:0] r_mask, w_mask_nxt;
  logic [NUM_POS-1:0] w_sel_mask;
  assign w_sel_mask = (r_state == IDLE) ? MASK : r_mask;
`endif

  bcd_scan_next u_next (
    .i_cur   (r_b),
    .i_last  (w_sel_last),
`ifdef BCD_SCAN_SKIP_MASK_EN
    .i_mask  (w_sel_mask),
`endif
    .o_first (w_first),
    .o_none  (w_none),
    .o_next  (w_next),
    .o_end   (w_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_busy_nxt  = r_busy;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_cont_nxt  = r_cont;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
`ifdef BCD_SCAN_SKIP_MASK_EN
    w_mask_nxt  = r_mask;
`endif
    unique case (r_state)
      IDLE: begin
        if (START && !STOP) begin
          w_cont_nxt  = CONT;
          w_last_nxt  = w_sel_last;
          w_dwell_nxt = DWELL;
`ifdef BCD_SCAN_SKIP_MASK_EN
          w_mask_nxt  = MASK;
`endif
          if (w_none) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = SCAN;
            w_b_nxt     = w_first;
            w_busy_nxt  = 1'b1;
            w_step_nxt  = 1'b1;
            w_cnt_nxt   = DWELL;
          end
        end
      end
      SCAN: begin
        if (STOP) begin
          w_state_nxt = IDLE;
          w_b_nxt     = BLANK_CODE;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!w_end) begin
          w_b_nxt    = w_next;
          w_cnt_nxt  = r_dwell;
          w_step_nxt = 1'b1;
        end else if (r_cont) begin
          w_b_nxt    = w_first;
          w_cnt_nxt  = r_dwell;
          w_step_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_b_nxt     = BLANK_CODE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_b     <= BLANK_CODE;
      r_busy  <= 1'b0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_last  <= '0;
      r_dwell <= '0;
`ifdef BCD_SCAN_SKIP_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
      r_busy  <= w_busy_nxt;
      r_step  <= w_step_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cont  <= w_cont_nxt;
      r_last  <= w_last_nxt;
      r_dwell <= w_dwell_nxt;
`ifdef BCD_SCAN_SKIP_MASK_EN
      r_mask  <= w_mask_nxt;
`endif
    end
  end

  assign B    = r_b;
  assign BUSY = r_busy;
  assign STEP = r_step;
  assign DONE = r_done;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed self-checking bench for bcd_scan_ctrl; mask cases run when
// BCD_SCAN_SKIP_MASK_EN is defined.
module tb_bcd_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START;
  logic        STOP;
  logic        CONT;
  logic [3:0]  LAST;
  logic [7:0]  DWELL;
`ifdef BCD_SCAN_SKIP_MASK_EN
  logic [10:0] MASK;
`endif
  logic [3:0]  B;
  logic        BUSY;
  logic        STEP;
  logic        DONE;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  bcd_scan_ctrl #(.DWELL_W(8)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .START (START),
    .STOP  (STOP),
    .CONT  (CONT),
    .LAST  (LAST),
    .DWELL (DWELL),
`ifdef BCD_SCAN_SKIP_MASK_EN
    .MASK  (MASK),
`endif
    .B     (B),
    .BUSY  (BUSY),
    .STEP  (STEP),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] b, input logic busy,
                           input logic step, input logic done);
    check({tag, ".B"},    16'(B),    16'(b));
    check({tag, ".BUSY"}, 16'(BUSY), 16'(busy));
    check({tag, ".STEP"}, 16'(STEP), 16'(step));
    check({tag, ".DONE"}, 16'(DONE), 16'(done));
  endtask

  // Presents a one-cycle START with the given settings; returns after the first scan edge.
  task automatic start_scan(input logic cont, input logic [3:0] last, input logic [7:0] dwell);
    CONT  = cont;
    LAST  = last;
    DWELL = dwell;
    START = 1'b1;
    tick();
    START = 1'b0;
    CONT  = 1'b0;
    LAST  = 4'd0;
    DWELL = 8'd0;
  endtask

  initial begin
    RSTN  = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    CONT  = 1'b0;
    LAST  = 4'd0;
    DWELL = 8'd0;
`ifdef BCD_SCAN_SKIP_MASK_EN
    MASK  = 11'd0;
`endif
    #12;
    check_out("reset", 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out("idle", 4'hF, 1'b0, 1'b0, 1'b0);
    end

    // Single pass, LAST=3, DWELL=1: each position held two cycles.
    start_scan(1'b0, 4'd3, 8'd1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      check_out("single", 4'(c / 2), 1'b1, (c % 2) == 0, 1'b0);
    end
    tick();
    check_out("single_end", 4'hF, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("single_after", 4'hF, 1'b0, 1'b0, 1'b0);

    // Continuous full scan with one-cycle dwell, stopped at B=5 on the second round.
    start_scan(1'b1, 4'd10, 8'd0);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) tick();
      check_out("cont", 4'(c % 11), 1'b1, 1'b1, 1'b0);
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check_out("stop", 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("stop_after", 4'hF, 1'b0, 1'b0, 1'b0);

    // LAST=13 clamps to 10; START held throughout the scan must not restart it.
    CONT  = 1'b0;
    LAST  = 4'd13;
    DWELL = 8'd0;
    START = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (DONE) done_cnt++;
      check_out("clamp", 4'(c), 1'b1, 1'b1, 1'b0);
    end
    tick();
    if (DONE) done_cnt++;
    check_out("clamp_end", 4'hF, 1'b0, 1'b0, 1'b1);
    START = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (DONE) done_cnt++;
      check_out("clamp_after", 4'hF, 1'b0, 1'b0, 1'b0);
    end
    check("clamp_done_count", 16'(done_cnt), 16'd1);

    // Asynchronous reset in the middle of B=2's dwell, then a fresh scan from 0.
    start_scan(1'b0, 4'd3, 8'd3);
    for (int c = 1; c < 10; c++) tick();
    check_out("pre_rst", 4'd2, 1'b1, 1'b0, 1'b0);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_rst.B", 16'(B), 16'hF);
    check("async_rst.BUSY", 16'(BUSY), 16'd0);
    #2;
    RSTN = 1'b1;
    tick();
    check_out("post_rst", 4'hF, 1'b0, 1'b0, 1'b0);
    start_scan(1'b0, 4'd1, 8'd0);
    check_out("restart0", 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("restart1", 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("restart_end", 4'hF, 1'b0, 1'b0, 1'b1);

    // LAST=0 continuous, DWELL=2: B stays 0 and STEP pulses every third cycle.
    start_scan(1'b1, 4'd0, 8'd2);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      check_out("last0", 4'd0, 1'b1, (c % 3) == 0, 1'b0);
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check_out("last0_stop", 4'hF, 1'b0, 1'b0, 1'b0);

    // START together with STOP in IDLE is refused.
    STOP = 1'b1;
    start_scan(1'b0, 4'd3, 8'd0);
    STOP = 1'b0;
    check_out("start_stop", 4'hF, 1'b0, 1'b0, 1'b0);

`ifdef BCD_SCAN_SKIP_MASK_EN
    MASK = 11'b000_0000_0101;
    start_scan(1'b0, 4'd4, 8'd0);
    MASK = 11'd0;
    check_out("mask0", 4'd1, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("mask1", 4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("mask2", 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("mask_end", 4'hF, 1'b0, 1'b0, 1'b1);

    MASK = 11'h01F;
    start_scan(1'b0, 4'd4, 8'd0);
    MASK = 11'd0;
    check_out("allmask", 4'hF, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("allmask_after", 4'hF, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
